// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported word memory.
// Handles byte/half stores via read-modify-write and flags misaligned or illegal accesses.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [1:0]               p0_size,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]    p0_wdata,
  output logic                     p0_gnt,
  output logic                     p0_done,
  output logic                     p0_err,
  output logic [DATA_WIDTH-1:0]    p0_rdata,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [1:0]               p1_size,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]    p1_wdata,
  output logic                     p1_gnt,
  output logic                     p1_done,
  output logic                     p1_err,
  output logic [DATA_WIDTH-1:0]    p1_rdata,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     owner_q, last_q, we_q, err_q;
  logic [1:0]               size_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q, cap_q, rdata0_q, rdata1_q, merged;

  logic                     acc, sel, s_we, s_err;
  logic [1:0]               s_size;
  logic [ADDRESS_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0]    s_wdata;

  // last_q holds the port granted most recently; reset value 1 favours p0
  always_comb begin
    acc     = (state_q == IDLE) && !rst && (p0_req || p1_req);
    sel     = p1_req && (!p0_req || !last_q);
    s_we    = sel ? p1_we    : p0_we;
    s_size  = sel ? p1_size  : p0_size;
    s_addr  = sel ? p1_addr  : p0_addr;
    s_wdata = sel ? p1_wdata : p0_wdata;
    s_err   = (s_size == 2'b11) ||
              (s_size == 2'b01 && s_addr[0]) ||
              (s_size == 2'b10 && s_addr[1:0] != 2'b00);
  end

  always_comb begin
    merged = cap_q;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    p0_done   = 1'b0;
    p1_done   = 1'b0;
    p0_err    = 1'b0;
    p1_err    = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        if (s_err)                state_d = DONE;
        else if (!s_we)           state_d = RD;
        else if (s_size == 2'b10) state_d = WR;
        else                      state_d = RMW_RD;
      end
      RD: begin
        mem_addr = addr_q;
        state_d  = DONE;
      end
      WR: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = !rst;
        state_d   = DONE;
      end
      RMW_RD: begin
        mem_addr = addr_q;
        state_d  = RMW_WR;
      end
      RMW_WR: begin
        mem_addr  = addr_q;
        mem_wdata = merged;
        mem_we    = !rst;
        state_d   = DONE;
      end
      DONE: begin
        p0_done = !rst && !owner_q;
        p1_done = !rst && owner_q;
        p0_err  = p0_done && err_q;
        p1_err  = p1_done && err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign p0_gnt   = acc && !sel;
  assign p1_gnt   = acc && sel;
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cap_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        owner_q <= sel;
        last_q  <= sel;
        we_q    <= s_we;
        err_q   <= s_err;
        size_q  <= s_size;
        addr_q  <= s_addr;
        wdata_q <= s_wdata;
      end
      if (state_q == RD) begin
        if (owner_q) rdata1_q <= mem_rdata;
        else         rdata0_q <= mem_rdata;
      end
      if (state_q == RMW_RD) cap_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected done/write events,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [1:0]  p0_size = 0, p1_size = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err, mem_we;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  int cyc = 0, nvec = 0, nmis = 0;

  typedef struct { bit port; bit err; bit chkrd; logic [31:0] rd; int cyc; } done_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  done_t dq[$];
  wr_t   wq[$];

  mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    done_t d;
    wr_t   w;
    if (p0_gnt && p1_gnt) chk("dual_gnt", 32'(p0_gnt & p1_gnt), 32'd0);
    if (p0_done || p1_done) begin
      if (dq.size() == 0) chk("unexpected_done", 32'({p1_done, p0_done}), 32'd0);
      else begin
        d = dq.pop_front();
        chk("done_port", 32'({p1_done, p0_done}), d.port ? 32'd2 : 32'd1);
        chk("done_err",  32'(p0_err | p1_err), 32'(d.err));
        chk("done_cyc",  32'(cyc), 32'(d.cyc));
        if (d.chkrd) chk("rdata", d.port ? p1_rdata : p0_rdata, d.rd);
      end
    end
    if (mem_we) begin
      if (wq.size() == 0) chk("unexpected_we", mem_addr, 32'hFFFF_FFFF);
      else begin
        w = wq.pop_front();
        chk("wr_addr", {mem_addr[31:2], 2'b00}, w.addr);
        chk("wr_data", mem_wdata, w.data);
        chk("wr_cyc",  32'(cyc), 32'(w.cyc));
      end
    end
  end

  task automatic issue(input bit port, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int lat, input bit err, input bit chkrd, input logic [31:0] exprd,
                       input int wr_off, input logic [31:0] wr_data);
    bit got = 0;
    done_t d;
    wr_t   w;
    @(posedge clk); #1;
    if (port) begin p1_req = 1; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata; end
    else      begin p0_req = 1; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (port ? p1_gnt : p0_gnt) got = 1;
    end
    if (!got) begin
      nvec++; nmis++;
      $display("FAIL gnt_timeout: port %0d addr %h never granted", port, addr);
    end else begin
      if (lat > 0) begin
        d.port = port; d.err = err; d.chkrd = chkrd; d.rd = exprd; d.cyc = cyc + lat;
        dq.push_back(d);
      end
      if (wr_off > 0) begin
        w.addr = {addr[31:2], 2'b00}; w.data = wr_data; w.cyc = cyc + wr_off;
        wq.push_back(w);
      end
    end
    @(posedge clk); #1;
    if (port) p1_req = 0; else p0_req = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((dq.size() != 0 || wq.size() != 0) && n < 40) begin
      @(negedge clk); n++;
    end
    if (dq.size() != 0 || wq.size() != 0) begin
      nvec++; nmis++;
      $display("FAIL drain_timeout: %0d dones and %0d writes still pending", dq.size(), wq.size());
      dq.delete(); wq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int g0, g1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_gnt",   32'({p1_gnt, p0_gnt}), 32'd0);
    chk("rst_done",  32'({p1_done, p0_done}), 32'd0);
    chk("rst_err",   32'({p1_err, p0_err}), 32'd0);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_rd0",   p0_rdata, 32'd0);
    chk("rst_rd1",   p1_rdata, 32'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("idle_addr",  mem_addr, 32'd0);
    chk("idle_wdata", mem_wdata, 32'd0);

    // word store then load back
    issue(0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 2, 0, 0, 0, 1, 32'hDEADBEEF);
    issue(0, 0, 2'b10, 32'h10, 0,            2, 0, 1, 32'hDEADBEEF, 0, 0);
    // byte RMW into lane 2
    issue(0, 1, 2'b10, 32'h20, 32'h11223344, 2, 0, 0, 0, 1, 32'h11223344);
    issue(1, 1, 2'b00, 32'h22, 32'h000000AA, 3, 0, 0, 0, 2, 32'h11AA3344);
    issue(1, 0, 2'b10, 32'h20, 0,            2, 0, 1, 32'h11AA3344, 0, 0);
    // misaligned half store: err, no write, rdata untouched
    issue(1, 1, 2'b01, 32'h23, 32'h0000BEEF, 1, 1, 1, 32'h11AA3344, 0, 0);
    wait_idle();
    chk("mem_0x20", mem[8], 32'h11AA3344);
    // more merge lanes
    issue(0, 1, 2'b10, 32'h24, 32'hCAFEF00D, 2, 0, 0, 0, 1, 32'hCAFEF00D);
    issue(0, 1, 2'b01, 32'h26, 32'h00001234, 3, 0, 0, 0, 2, 32'h1234F00D);
    issue(1, 1, 2'b00, 32'h27, 32'h00000099, 3, 0, 0, 0, 2, 32'h9934F00D);
    issue(0, 1, 2'b00, 32'h24, 32'hFFFFFF01, 3, 0, 0, 0, 2, 32'h9934F001);
    issue(1, 0, 2'b00, 32'h25, 0,            2, 0, 1, 32'h9934F001, 0, 0);
    // illegal size and misaligned word load
    issue(0, 0, 2'b11, 32'h10, 0,            1, 1, 1, 32'hDEADBEEF, 0, 0);
    issue(0, 0, 2'b10, 32'h11, 0,            1, 1, 1, 32'hDEADBEEF, 0, 0);
    wait_idle();

    // reset during RMW_RD aborts the store
    issue(0, 1, 2'b10, 32'h30, 32'h55667788, 2, 0, 0, 0, 1, 32'h55667788);
    wait_idle();
    issue(1, 1, 2'b00, 32'h31, 32'h000000EE, 0, 0, 0, 0, 0, 0);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (5) @(negedge clk);
    chk("abort_mem", mem[12], 32'h55667788);
    chk("abort_rd1", p1_rdata, 32'd0);
    issue(1, 0, 2'b10, 32'h30, 0, 2, 0, 1, 32'h55667788, 0, 0);
    wait_idle();

    // simultaneous requests from reset: p0 first, p1 at the next IDLE cycle
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    p0_req = 1; p0_we = 0; p0_size = 2'b10; p0_addr = 32'h10;
    p1_req = 1; p1_we = 0; p1_size = 2'b10; p1_addr = 32'h20;
    g0 = -1; g1 = -1;
    for (int i = 0; i < 20 && (p0_req || p1_req); i++) begin
      done_t d;
      @(negedge clk);
      if (p0_gnt) begin
        g0 = cyc;
        d.port = 0; d.err = 0; d.chkrd = 1; d.rd = 32'hDEADBEEF; d.cyc = cyc + 2;
        dq.push_back(d);
      end
      if (p1_gnt) begin
        g1 = cyc;
        d.port = 1; d.err = 0; d.chkrd = 1; d.rd = 32'h11AA3344; d.cyc = cyc + 2;
        dq.push_back(d);
      end
      @(posedge clk); #1;
      if (g0 >= 0) p0_req = 0;
      if (g1 >= 0) p1_req = 0;
    end
    p0_req = 0; p1_req = 0;
    chk("rr_p0_granted", 32'(g0 >= 0), 32'd1);
    chk("rr_p1_after",   32'(g1 - g0), 32'd3);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width of both request ports and the memory port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; the byte-lane logic is defined for 32 only.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports p0_req/p1_req  input  1  access request from requester N; held until gnt.
REQ-006 SHALL have ports p0_we/p1_we  input  1  1=store, 0=load.
REQ-007 SHALL have ports p0_size/p1_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have ports p0_addr/p1_addr  input  ADDRESS_WIDTH  byte address.
REQ-009 SHALL have ports p0_wdata/p1_wdata  input  DATA_WIDTH  store data, right-justified.
REQ-010 SHALL have ports p0_gnt/p1_gnt  output  1  request accepted this cycle; request fields sampled.
REQ-011 SHALL have ports p0_done/p1_done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports p0_err/p1_err  output  1  pulses with done when the access was misaligned or illegal.
REQ-013 SHALL have ports p0_rdata/p1_rdata  output  DATA_WIDTH  full aligned word read; valid from done until the next done on that port.
REQ-014 SHALL have port mem_we  output  1  word write strobe to the data memory.
REQ-015 SHALL have port mem_addr  output  ADDRESS_WIDTH  byte address to memory; the memory ignores [1:0].
REQ-016 SHALL have port mem_wdata  output  DATA_WIDTH  word written when mem_we=1.
REQ-017 SHALL have port mem_rdata  input  DATA_WIDTH  combinational read of mem_addr.

Function
REQ-018 SHALL implement the FSM states IDLE, RD, WR, RMW_RD, RMW_WR, DONE; only one access is in flight at a time.
REQ-019 In IDLE with at least one req, SHALL accept one request: gnt is asserted combinationally for that cycle, and addr/we/size/wdata/owner are latched.
REQ-020 SHALL arbitrate round-robin: with both req high, grant the port not granted last; a lone req is granted immediately; the pointer resets to favour p0.
REQ-021 Alignment SHALL be checked at accept: half needs addr[0]=0, word needs addr[1:0]=00, size 11 is illegal; a failing access goes straight to DONE with err=1, no mem_we, and rdata unchanged.
REQ-022 A load SHALL sequence IDLE->RD->DONE; in RD mem_addr=latched addr and mem_rdata is registered into the owner's rdata; done is asserted 2 cycles after gnt.
REQ-023 A word store SHALL sequence IDLE->WR->DONE; in WR mem_we=1 and mem_wdata=wdata; done is asserted 2 cycles after gnt.
REQ-024 A byte/half store SHALL sequence IDLE->RMW_RD->RMW_WR->DONE; RMW_RD captures mem_rdata, and RMW_WR writes the merged word with mem_we=1; done is asserted 3 cycles after gnt.
REQ-025 Merge rule: for a byte, lane addr[1:0] gets wdata[7:0]; for a half, lanes {1,0} (addr[1]=0) or {3,2} (addr[1]=1) get wdata[15:0]; all other lanes are kept from the captured word.
REQ-026 DONE SHALL last one cycle, pulse only the owner's done (and err if flagged), and return to IDLE; no accept in DONE.
REQ-027 mem_we SHALL be 1 only in WR and RMW_WR; outside active states mem_addr=0 and mem_wdata=0.
REQ-028 A requester dropping req before gnt SHALL forfeit without side effect; gnt is never asserted to both ports in one cycle.

Reset
REQ-029 rst SHALL force IDLE, pointer to favour p0, and all gnt/done/err/mem_we to 0; rdata registers clear to 0.
REQ-030 rst mid-access (including in RMW_WR) SHALL abort: no mem_we in the cycle after the reset edge and no done is issued for the aborted access.

Verification
REQ-031 p0 word store addr 0x10 data 0xDEADBEEF, then p0 load 0x10 -> store done at gnt+2; load done at gnt+2 with p0_rdata=0xDEADBEEF.
REQ-032 Word 0x11223344 at 0x20; p1 byte store addr 0x22 data 0xAA -> one mem_we at gnt+2 with mem_wdata=0x11AA3344; p1_done at gnt+3.
REQ-033 p0 and p1 load requests held simultaneously from reset -> p0 granted first, p1 granted in the next IDLE cycle; never both gnt in one cycle.
REQ-034 p1 half store addr 0x23 -> p1_done=p1_err=1 at gnt+1 (DONE); no mem_we; memory word unchanged.
REQ-035 rst asserted during RMW_RD of a byte store -> next cycle IDLE, mem_we=0 throughout, no done; memory word unchanged.
